// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP accelerator result path: matrix geometry,
// drain FSM states and the packed result-matrix type.
package mlp_pkg;

  localparam int DATA_W     = 16;
  localparam int MAT_DIM    = 16;
  localparam int BEATS      = MAT_DIM * MAT_DIM / 2;
  localparam int BEAT_CNT_W = $clog2(BEATS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic signed [DATA_W-1:0] elem_t;

  // Packed result matrix, indexed [row][col]
  typedef elem_t [MAT_DIM-1:0][MAT_DIM-1:0] mat_t;

  typedef logic [2*DATA_W-1:0] beat_t;

endpackage

// File: rtl/result_drain_if.sv
// Result readout stream: valid/payload from the drain, ready from the consumer.
interface result_drain_if #(
  parameter int DATA_W = mlp_pkg::DATA_W
);

  logic                  result_valid_o;
  logic [2*DATA_W-1:0]   result_payload_o;
  logic                  result_ready_i;

  modport master (
    output result_valid_o,
    output result_payload_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o,
    input  result_payload_o,
    output result_ready_i
  );

endinterface

// File: rtl/result_drain.sv
// Streams the 16x16 result matrix out as 32-bit beats, two elements per beat
// with the odd-column element in the high half. Beat k covers row k/8 and
// column pair k%8. The matrix is read beat by beat, so it must stay stable
// while busy_o is high.
module result_drain #(
  parameter int DATA_W  = mlp_pkg::DATA_W,
  parameter int MAT_DIM = mlp_pkg::MAT_DIM
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_i,
  input  logic                                        abort_i,
  input  logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_W-1:0] matrix_i,
  result_drain_if.master                              rd,
  output logic                                        busy_o,
  output logic                                        done_o
);

  import mlp_pkg::state_t;
  import mlp_pkg::IDLE;
  import mlp_pkg::SEND;

  localparam int BEATS = MAT_DIM * MAT_DIM / 2;
  localparam int ROW_W = $clog2(MAT_DIM);
  localparam int COL_W = $clog2(MAT_DIM / 2);
  localparam int CNT_W = ROW_W + COL_W;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Select beat k: row from the upper count bits, column pair from the lower bits
  function automatic logic [2*DATA_W-1:0] beat_word(
    input logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_W-1:0] m,
    input logic [CNT_W-1:0]                            k
  );
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pair;
    logic [ROW_W-1:0] col_lo;
    logic [ROW_W-1:0] col_hi;
    row    = k[CNT_W-1 -: ROW_W];
    pair   = k[COL_W-1:0];
    col_lo = {pair, 1'b0};
    col_hi = {pair, 1'b1};
    return {m[row][col_hi], m[row][col_lo]};
  endfunction

  state_t               state_q,   state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 valid_q,   valid_d;
  logic [2*DATA_W-1:0]  payload_q, payload_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic                 accept;
  logic [CNT_W-1:0]     beat_nxt;

  assign accept   = valid_q & rd.result_ready_i;
  assign beat_nxt = beat_cnt_q + 1'b1;

  // Next-state logic: start loads beat 0, each acceptance loads the next beat,
  // abort wins over a same-cycle acceptance and never produces done
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = valid_q;
    payload_d  = payload_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          payload_d  = beat_word(matrix_i, '0);
          valid_d    = 1'b1;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_nxt;
            payload_d  = beat_word(matrix_i, beat_nxt);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == SEND);
  end

  // State, counter and registered outputs; reset drops valid immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      payload_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      payload_q  <= payload_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd.result_valid_o   = valid_q;
  assign rd.result_payload_o = payload_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a vector table for the first handshake
// cycles, then full-stream sequences covering ready toggling, abort, ignored
// restart, restart in the done cycle and mid-stream reset.
module tb_result_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic busy;
  logic done;
  logic [15:0][15:0][15:0] mat;

  result_drain_if rif ();

  result_drain dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .matrix_i (mat),
    .rd       (rif),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] got [128];

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        ev;
    logic [31:0] epl;
    logic        chk_pl;
    logic        eb;
    logic        ed;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic s, input logic a, input logic r,
                              input logic ev, input logic [31:0] epl,
                              input logic chk, input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.abort = a; v.ready = r; v.ev = ev;
    v.epl = epl; v.chk_pl = chk; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input int k);
    int r;
    int c;
    r = k / 8;
    c = k % 8;
    return {mat[r][2*c+1], mat[r][2*c]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", {31'b0, rif.result_valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    tick();
  endtask

  // Runs one stream. pattern 0: ready always high; 1: ready 1,0,0,1 repeating.
  // abort_beat / restart_beat / rst_beat: beat index at which to inject (-1 = never).
  task automatic drain(input int pattern, input int abort_beat, input int restart_beat,
                       input int rst_beat, input bit start_on_done, output int done_cyc);
    int idx;
    int cyc;
    bit acc;
    bit fin;
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    done_cyc = -1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_valid", {31'b0, rif.result_valid_o}, 32'd1);
    check("start_busy", {31'b0, busy}, 32'd1);
    while (!fin && cyc < 2000) begin
      rif.result_ready_i = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      abort_i = (idx == abort_beat);
      start_i = (idx == restart_beat);
      check($sformatf("beat%0d", idx), rif.result_payload_o, exp_beat(idx));
      if (idx == rst_beat) begin
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, rif.result_valid_o}, 32'd0);
        check("midrst_payload", rif.result_payload_o, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        tick();
        rst = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("postrst_valid", {31'b0, rif.result_valid_o}, 32'd0);
          check("postrst_busy", {31'b0, busy}, 32'd0);
          check("postrst_done", {31'b0, done}, 32'd0);
        end
        fin = 1'b1;
      end else if (abort_i) begin
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_valid", {31'b0, rif.result_valid_o}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        tick();
        check("abort_done2", {31'b0, done}, 32'd0);
        check("abort_valid2", {31'b0, rif.result_valid_o}, 32'd0);
        fin = 1'b1;
      end else begin
        acc = rif.result_valid_o && rif.result_ready_i;
        if (acc) got[idx] = rif.result_payload_o;
        tick();
        start_i = 1'b0;
        cyc++;
        if (acc) idx++;
        check("done", {31'b0, done}, {31'b0, idx == 128});
        check("valid", {31'b0, rif.result_valid_o}, {31'b0, idx < 128});
        check("busy", {31'b0, busy}, {31'b0, idx < 128});
        if (idx == 128) begin
          done_cyc = cyc;
          fin = 1'b1;
          if (start_on_done) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            check("rdone_valid", {31'b0, rif.result_valid_o}, 32'd1);
            check("rdone_beat0", rif.result_payload_o, exp_beat(0));
            check("rdone_busy", {31'b0, busy}, 32'd1);
            check("rdone_done", {31'b0, done}, 32'd0);
          end else begin
            for (int i = 0; i < 3; i++) begin
              tick();
              check("post_done", {31'b0, done}, 32'd0);
              check("post_valid", {31'b0, rif.result_valid_o}, 32'd0);
              check("post_busy", {31'b0, busy}, 32'd0);
            end
          end
        end
      end
    end
    if (!fin) check("stream_timeout", 32'd0, 32'd1);
    abort_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    int dc;
    rif.result_ready_i = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mat[r][c] = 16'(r * 16 + c);

    tbl[0] = mk(0, 0, 1, 0, 32'h0000_0000, 1, 0, 0);
    tbl[1] = mk(1, 0, 0, 1, 32'h0001_0000, 1, 1, 0);
    tbl[2] = mk(0, 0, 0, 1, 32'h0001_0000, 1, 1, 0);
    tbl[3] = mk(0, 0, 1, 1, 32'h0003_0002, 1, 1, 0);
    tbl[4] = mk(0, 0, 1, 1, 32'h0005_0004, 1, 1, 0);
    tbl[5] = mk(1, 0, 0, 1, 32'h0005_0004, 1, 1, 0);
    tbl[6] = mk(0, 1, 1, 0, 32'h0000_0000, 0, 0, 0);
    tbl[7] = mk(0, 1, 1, 0, 32'h0000_0000, 0, 0, 0);
    tbl[8] = mk(1, 0, 1, 1, 32'h0001_0000, 1, 1, 0);

    // Reset state
    tick();
    check("reset_valid", {31'b0, rif.result_valid_o}, 32'd0);
    check("reset_payload", rif.result_payload_o, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    tick();

    // Table: start, hold on ready low, accept, ignored start, abort priority, idle abort
    for (int i = 0; i < 9; i++) begin
      start_i = tbl[i].start;
      abort_i = tbl[i].abort;
      rif.result_ready_i = tbl[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, rif.result_valid_o}, {31'b0, tbl[i].ev});
      if (tbl[i].chk_pl)
        check($sformatf("vec%0d_payload", i), rif.result_payload_o, tbl[i].epl);
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
      check($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, tbl[i].ed});
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    do_reset();

    // Full ramp stream, ready high: done 128 edges after the start edge (129 including it)
    drain(0, -1, -1, -1, 1'b0, dc);
    check("ramp_beat0", got[0], 32'h0001_0000);
    check("ramp_beat1", got[1], 32'h0003_0002);
    check("ramp_beat127", got[127], 32'h00FF_00FE);
    check("ramp_done_latency", 32'(dc), 32'd128);

    // Signed data with ready toggling 1,0,0,1
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mat[r][c] = 16'(r * 4099 + c * 613) ^ 16'h8001;
    mat[0][1] = -16'sd5;
    mat[15][15] = 16'h8000;
    drain(1, -1, -1, -1, 1'b0, dc);
    check("neg_beat0_hi", {16'b0, got[0][31:16]}, 32'h0000_FFFB);
    check("neg_beat127_hi", {16'b0, got[127][31:16]}, 32'h0000_8000);

    // Abort at beat 40, then a fresh stream from beat 0
    drain(0, 40, -1, -1, 1'b0, dc);
    drain(0, -1, -1, -1, 1'b0, dc);
    check("after_abort_latency", 32'(dc), 32'd128);

    // Start re-asserted at beat 10 is ignored
    drain(0, -1, 10, -1, 1'b0, dc);
    check("restart_ignored_latency", 32'(dc), 32'd128);

    // Start in the done cycle begins a second stream
    drain(0, -1, -1, -1, 1'b1, dc);
    do_reset();

    // Reset at beat 64
    drain(0, -1, -1, 64, 1'b0, dc);
    check("midrst_no_done", 32'(dc), 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
